// File: rtl/mpu_result_streamer_if.sv
// Stream-side bundle of mpu_result_streamer: capture request, matrix snapshot source
// and the valid/ready element stream with its sideband indices.
interface mpu_result_streamer_if #(
  parameter int DIM    = 5,
  parameter int ELEM_W = 8,
  parameter int SIZE_W = 8
);
  logic                      start;
  logic [SIZE_W-1:0]         size;
  logic [DIM*DIM*ELEM_W-1:0] matrix_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [ELEM_W-1:0]         out_data;
  logic [2:0]                out_row;
  logic [2:0]                out_col;
  logic                      out_last;
  logic                      busy;
  logic                      done;

  modport master (
    output start, size, matrix_in, out_ready,
    input  out_valid, out_data, out_row, out_col, out_last, busy, done
  );

  modport slave (
    input  start, size, matrix_in, out_ready,
    output out_valid, out_data, out_row, out_col, out_last, busy, done
  );
endinterface

// File: rtl/mpu_result_streamer.sv
// Snapshots a DIM x DIM result matrix on start and streams the active n x n window
// row-major over valid/ready, then pulses done for one cycle.
module mpu_result_streamer #(
  parameter int DIM    = 5,
  parameter int ELEM_W = 8,
  parameter int SIZE_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  mpu_result_streamer_if.slave bus
);
  localparam int IDX_W  = 3;
  localparam int FLAT_W = $clog2(DIM * DIM);
  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   n_q;
  logic [IDX_W-1:0]   row_q;
  logic [IDX_W-1:0]   col_q;
  logic [ELEM_W-1:0]  snap_q [DIM*DIM];
  logic [ELEM_W-1:0]  data_q;
  logic               valid_q;
  logic               last_q;
  logic               done_q;

  logic [IDX_W-1:0]   size_n;
  logic               accept;
  logic [IDX_W-1:0]   row_d;
  logic [IDX_W-1:0]   col_d;
  logic               last_d;
  logic [FLAT_W-1:0]  flat_d;

  // Sizes above DIM clamp to DIM; zero stays zero and produces an empty transfer.
  function automatic logic [IDX_W-1:0] eff_size(input logic [SIZE_W-1:0] s);
    if (s > SIZE_W'(DIM)) return IDX_W'(DIM);
    return s[IDX_W-1:0];
  endfunction

  always_comb begin
    size_n = eff_size(bus.size);
    accept = valid_q && bus.out_ready;
    row_d  = row_q;
    col_d  = col_q + ONE;
    if (col_q == n_q - ONE) begin
      row_d = row_q + ONE;
      col_d = '0;
    end
    last_d = (row_d == n_q - ONE) && (col_d == n_q - ONE);
    flat_d = FLAT_W'(row_d) * FLAT_W'(DIM) + FLAT_W'(col_d);
  end

  // Outputs are fully registered: the next element is fetched from the snapshot
  // on the accepting edge so data/indices hold steady through any stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < DIM * DIM; k++) snap_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            if (size_n != '0) begin
              for (int k = 0; k < DIM * DIM; k++)
                snap_q[k] <= bus.matrix_in[k*ELEM_W +: ELEM_W];
              n_q     <= size_n;
              row_q   <= '0;
              col_q   <= '0;
              data_q  <= bus.matrix_in[ELEM_W-1:0];
              last_q  <= (size_n == ONE);
              valid_q <= 1'b1;
              state_q <= STREAM;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              row_q  <= row_d;
              col_q  <= col_d;
              data_q <= snap_q[flat_d];
              last_q <= last_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.busy      = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_last  = last_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_mpu_result_streamer.sv
// Directed bench for mpu_result_streamer: ordering, clamping, stalls, snapshot
// isolation, mid-stream reset and done timing.
module tb_mpu_result_streamer;
  localparam int DIM    = 5;
  localparam int ELEM_W = 8;
  localparam int SIZE_W = 8;
  localparam int MW     = DIM * DIM * ELEM_W;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mpu_result_streamer_if #(.DIM(DIM), .ELEM_W(ELEM_W), .SIZE_W(SIZE_W)) bus ();

  mpu_result_streamer #(.DIM(DIM), .ELEM_W(ELEM_W), .SIZE_W(SIZE_W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Results of the most recent collect run
  int q_data[$];
  int q_row[$];
  int q_col[$];
  int q_last[$];
  int stall_err, busy_err, valid_cycles, first_lbl, done_lbl;
  logic done_valid, done_busy, done_next;
  int start_lbl;

  function automatic logic [MW-1:0] mk(input int base);
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        m[(i*DIM+j)*ELEM_W +: ELEM_W] = ELEM_W'(base + 10*i + j);
    return m;
  endfunction

  task automatic raise_start(input int sz, input logic [MW-1:0] m);
    @(negedge clk);
    bus.matrix_in = m;
    bus.size      = SIZE_W'(sz);
    bus.start     = 1'b1;
    start_lbl     = cyc;
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0; 2: ready low for 5 cycles then high
  task automatic collect(input int mode, input int limit, input bit disturb, input logic [MW-1:0] alt);
    bit r, prev_stall;
    int pd, pr, pc, pl;
    q_data.delete(); q_row.delete(); q_col.delete(); q_last.delete();
    stall_err = 0; busy_err = 0; valid_cycles = 0; first_lbl = -1; done_lbl = -1;
    done_valid = 1'bx; done_busy = 1'bx; done_next = 1'bx;
    prev_stall = 0; pd = 0; pr = 0; pc = 0; pl = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      if (disturb && i == 3) begin bus.matrix_in = alt; bus.start = 1'b1; end
      if (disturb && i == 4) bus.start = 1'b0;
      if (bus.done) begin
        done_lbl   = cyc;
        done_valid = bus.out_valid;
        done_busy  = bus.busy;
        bus.out_ready = 1'b0;
        @(negedge clk);
        done_next = bus.done;
        return;
      end
      if (bus.busy !== bus.out_valid) busy_err++;
      if (bus.out_valid) begin
        valid_cycles++;
        if (first_lbl < 0) first_lbl = cyc;
        if (prev_stall && (int'(bus.out_data) != pd || int'(bus.out_row) != pr ||
                           int'(bus.out_col) != pc || int'(bus.out_last) != pl)) stall_err++;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (i % 3 == 0);
        default: r = (i >= 5);
      endcase
      bus.out_ready = r;
      if (bus.out_valid && r) begin
        q_data.push_back(int'(bus.out_data));
        q_row.push_back(int'(bus.out_row));
        q_col.push_back(int'(bus.out_col));
        q_last.push_back(int'(bus.out_last));
      end
      prev_stall = bus.out_valid && !r;
      pd = int'(bus.out_data); pr = int'(bus.out_row);
      pc = int'(bus.out_col);  pl = int'(bus.out_last);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.size = '0; bus.matrix_in = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.out_data !== '0 || bus.out_row !== '0 || bus.out_col !== '0 || bus.out_last !== 1'b0) begin
      errors++; $display("FAIL reset_fields: got data %0d row %0d col %0d last %b expected all 0",
                         bus.out_data, bus.out_row, bus.out_col, bus.out_last);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();  // size 3, ready high
    raise_start(3, mk(0));
    collect(0, 40, 1'b0, '0);
    checks++; if (q_data.size() != 9) begin errors++; $display("FAIL t1_beats: got %0d expected 9", q_data.size()); end
    for (int k = 0; k < q_data.size() && k < 9; k++) begin
      checks++;
      if (q_row[k] != k/3 || q_col[k] != k%3 || q_data[k] != 10*(k/3) + k%3 || q_last[k] != (k == 8)) begin
        errors++; $display("FAIL t1_beat%0d: got row %0d col %0d data %0d last %0d expected %0d %0d %0d %0d",
                           k, q_row[k], q_col[k], q_data[k], q_last[k], k/3, k%3, 10*(k/3)+k%3, k == 8);
      end
    end
    checks++; if (first_lbl != start_lbl + 1) begin errors++; $display("FAIL t1_first_latency: got %0d expected %0d", first_lbl - start_lbl, 1); end
    checks++; if (done_lbl != start_lbl + 10) begin errors++; $display("FAIL t1_done_latency: got %0d expected %0d", done_lbl - start_lbl, 10); end
    checks++; if (done_valid !== 1'b0 || done_busy !== 1'b0 || done_next !== 1'b0) begin
      errors++; $display("FAIL t1_done_cycle: got valid %b busy %b done_next %b expected 0 0 0", done_valid, done_busy, done_next);
    end
    checks++; if (busy_err != 0) begin errors++; $display("FAIL t1_busy_tracks_valid: got %0d expected 0", busy_err); end
  endtask

  task automatic test_stall();  // size 5, ready 1,0,0
    raise_start(5, mk(0));
    collect(1, 120, 1'b0, '0);
    checks++; if (q_data.size() != 25) begin errors++; $display("FAIL t2_beats: got %0d expected 25", q_data.size()); end
    for (int k = 0; k < q_data.size() && k < 25; k++) begin
      checks++;
      if (q_row[k] != k/5 || q_col[k] != k%5 || q_data[k] != 10*(k/5) + k%5 || q_last[k] != (k == 24)) begin
        errors++; $display("FAIL t2_beat%0d: got row %0d col %0d data %0d last %0d expected %0d %0d %0d %0d",
                           k, q_row[k], q_col[k], q_data[k], q_last[k], k/5, k%5, 10*(k/5)+k%5, k == 24);
      end
    end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL t2_hold_stable: got %0d changes expected 0", stall_err); end
    checks++; if (done_lbl != start_lbl + 74) begin errors++; $display("FAIL t2_done_latency: got %0d expected %0d", done_lbl - start_lbl, 74); end
  endtask

  task automatic test_clamp();  // size 9 clamps to 5; size 0 is empty
    raise_start(9, mk(0));
    collect(0, 40, 1'b0, '0);
    checks++; if (q_data.size() != 25) begin errors++; $display("FAIL t3_clamp_beats: got %0d expected 25", q_data.size()); end
    checks++; if (q_data.size() == 25 && (q_data[24] != 44 || q_last[24] != 1 || q_data[5] != 10)) begin
      errors++; $display("FAIL t3_clamp_data: got last %0d/%0d row1 %0d expected 44/1 10", q_data[24], q_last[24], q_data[5]);
    end
    checks++; if (done_lbl != start_lbl + 26) begin errors++; $display("FAIL t3_clamp_done: got %0d expected %0d", done_lbl - start_lbl, 26); end
    raise_start(0, mk(0));
    collect(0, 10, 1'b0, '0);
    checks++; if (valid_cycles != 0) begin errors++; $display("FAIL t3_zero_valid: got %0d expected 0", valid_cycles); end
    checks++; if (done_lbl != start_lbl + 1) begin errors++; $display("FAIL t3_zero_done: got %0d expected %0d", done_lbl - start_lbl, 1); end
  endtask

  task automatic test_snapshot();  // matrix and start disturbed mid-stream
    raise_start(4, mk(0));
    collect(0, 40, 1'b1, mk(100));
    checks++; if (q_data.size() != 16) begin errors++; $display("FAIL t4_beats: got %0d expected 16", q_data.size()); end
    for (int k = 0; k < q_data.size() && k < 16; k++) begin
      checks++;
      if (q_data[k] != 10*(k/4) + k%4 || q_row[k] != k/4 || q_col[k] != k%4) begin
        errors++; $display("FAIL t4_beat%0d: got data %0d row %0d col %0d expected %0d %0d %0d",
                           k, q_data[k], q_row[k], q_col[k], 10*(k/4)+k%4, k/4, k%4);
      end
    end
    checks++; if (done_lbl != start_lbl + 17) begin errors++; $display("FAIL t4_done_latency: got %0d expected %0d", done_lbl - start_lbl, 17); end
  endtask

  task automatic test_reset_mid();  // reset on beat 4 of a size-4 stream
    int seen_done, seen_valid;
    raise_start(4, mk(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      bus.out_ready = 1'b1;
      if (i == 4) rst = 1'b1;
    end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL t5_after_reset: got valid %b busy %b expected 0 0", bus.out_valid, bus.busy);
    end
    rst = 1'b0;
    seen_done = int'(bus.done); seen_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen_done  += int'(bus.done);
      seen_valid += int'(bus.out_valid);
    end
    checks++; if (seen_done != 0 || seen_valid != 0) begin
      errors++; $display("FAIL t5_no_done: got done %0d valid %0d expected 0 0", seen_done, seen_valid);
    end
    raise_start(1, mk(100));
    collect(0, 10, 1'b0, '0);
    checks++; if (q_data.size() != 1 || q_data[0] != 100 || q_row[0] != 0 || q_col[0] != 0 || q_last[0] != 1) begin
      errors++; $display("FAIL t5_restart_beat: got %0d beats first data %0d expected 1 beat data 100 last 1",
                         q_data.size(), (q_data.size() > 0) ? q_data[0] : -1);
    end
    checks++; if (done_lbl != start_lbl + 2) begin errors++; $display("FAIL t5_restart_done: got %0d expected %0d", done_lbl - start_lbl, 2); end
  endtask

  task automatic test_single_stall();  // size 1, ready low 5 cycles
    raise_start(1, mk(7));
    collect(2, 20, 1'b0, '0);
    checks++; if (valid_cycles != 6) begin errors++; $display("FAIL t6_valid_held: got %0d expected 6", valid_cycles); end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL t6_hold_stable: got %0d changes expected 0", stall_err); end
    checks++; if (q_data.size() != 1 || q_data[0] != 7 || q_last[0] != 1) begin
      errors++; $display("FAIL t6_beat: got %0d beats data %0d expected 1 beat data 7 last 1",
                         q_data.size(), (q_data.size() > 0) ? q_data[0] : -1);
    end
    checks++; if (done_lbl != start_lbl + 7) begin errors++; $display("FAIL t6_done_latency: got %0d expected %0d", done_lbl - start_lbl, 7); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_clamp();
    test_snapshot();
    test_reset_mid();
    test_single_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
